events_rate_sequencer: RTL

Acquisition sequencer driving the external side of `EventsRateInterface`. It opens a fixed-length counting window, requests a read, and snapshots the per-channel event counts when the counter block reports ready. It then streams one word per enabled channel over a valid/ready port and clears the counters before the next window. It sits directly downstream of the events-rate counter block, between it and the readout/host link.

---
 rtl/events_rate_sequencer_pkg.sv | 5 +
 rtl/events_rate_sequencer_if.sv | 13 +
 rtl/events_rate_gate_timer.sv | 17 +
 rtl/events_rate_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/events_rate_sequencer_pkg.sv
// EventsRatePackage: shared state encoding and channel-id width for the events-rate sequencer.
package EventsRatePackage;
    localparam int CHAN_ID_W = 8;
    typedef enum logic [2:0] {IDLE, CLEAR, GATE, REQUEST, WAIT_READY, STREAM} events_rate_seq_state_t;
endpackage

// File: rtl/events_rate_sequencer_if.sv
// EventsRateInterface: control and count bundle between the counter block and its sequencer.
interface EventsRateInterface #(
    parameter int COUNTER_LENGTH = 24,
    parameter int CHANNEL_NUMBER = 2
) ();
    logic [CHANNEL_NUMBER-1:0]                     enable;
    logic                                          read;
    logic                                          clear;
    logic                                          events_rate_ready;
    logic [CHANNEL_NUMBER-1:0][COUNTER_LENGTH-1:0] event_count;
    modport external (output enable, output read, output clear, input events_rate_ready, input event_count);
    modport internal (input enable, input read, input clear, output events_rate_ready, output event_count);
endinterface

// File: rtl/events_rate_gate_timer.sv
// events_rate_gate_timer: loadable down-counter; done is high during the last counted cycle.
module events_rate_gate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);
    logic [W-1:0] count_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= '0;
        else if (load_i) count_q <= value_i;
        else if (count_q != '0) count_q <= count_q - W'(1);
    assign done_o = count_q == W'(1);
endmodule

// File: rtl/events_rate_sequencer.sv
// events_rate_sequencer: gates the counter block for a fixed window, snapshots counts on ready,
// and streams one {channel, count} word per enabled channel before clearing for the next window.
module events_rate_sequencer
    import EventsRatePackage::*;
#(
    parameter int COUNTER_LENGTH = 24,
    parameter int CHANNEL_NUMBER = 2,
    parameter int GATE_CYCLES    = 1_000_000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    EventsRateInterface.external                rate_if,
    input  logic                                cfg_start,
    input  logic                                cfg_stop,
    input  logic [CHANNEL_NUMBER-1:0]           channel_mask,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CHAN_ID_W+COUNTER_LENGTH-1:0] out_data,
    output logic                                out_last,
    output logic                                busy,
    output logic                                timeout_error
);
    localparam int MAXC = GATE_CYCLES > TIMEOUT_CYCLES ? GATE_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam int IW = CHANNEL_NUMBER > 1 ? $clog2(CHANNEL_NUMBER) : 1;

    events_rate_seq_state_t state_q;
    logic [CHANNEL_NUMBER-1:0] mask_q, enable_q;
    logic read_q, clear_q, out_valid_q, out_last_q, busy_q, timeout_q, stop_q, first_q;
    logic [CHAN_ID_W+COUNTER_LENGTH-1:0] out_data_q;
    logic [CHAN_ID_W-1:0] idx_q, first_idx, next_idx, last_idx;
    logic [COUNTER_LENGTH-1:0] snap_q [2**IW];
    logic timer_done;

    // One timer serves both waits: armed for the gate from CLEAR, for the ready wait from REQUEST.
    events_rate_gate_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (state_q == CLEAR || state_q == REQUEST),
        .value_i (state_q == CLEAR ? TW'(GATE_CYCLES) : TW'(TIMEOUT_CYCLES)),
        .done_o  (timer_done)
    );

    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        last_idx  = '0;
        for (int i = CHANNEL_NUMBER - 1; i >= 0; i--) begin
            if (mask_q[i]) first_idx = 8'(i);
            if (mask_q[i] && 8'(i) > idx_q) next_idx = 8'(i);
        end
        for (int i = 0; i < CHANNEL_NUMBER; i++)
            if (mask_q[i]) last_idx = 8'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            enable_q    <= '0;
            read_q      <= 1'b0;
            clear_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stop_q      <= 1'b0;
            first_q     <= 1'b0;
            idx_q       <= '0;
            for (int i = 0; i < 2**IW; i++) snap_q[i] <= '0;
        end else begin
            if (cfg_stop && state_q != IDLE) stop_q <= 1'b1;
            case (state_q)
                IDLE: if (cfg_start && |channel_mask) begin
                    mask_q    <= channel_mask;
                    timeout_q <= 1'b0;
                    stop_q    <= cfg_stop;
                    first_q   <= 1'b1;
                    clear_q   <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= CLEAR;
                end
                // The clear right after start never honours stop, so start+stop still yields one window.
                CLEAR: begin
                    clear_q <= 1'b0;
                    first_q <= 1'b0;
                    if ((stop_q || cfg_stop) && !first_q) begin
                        stop_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        enable_q <= mask_q;
                        state_q  <= GATE;
                    end
                end
                GATE: if (timer_done) begin
                    enable_q <= '0;
                    read_q   <= 1'b1;
                    state_q  <= REQUEST;
                end
                REQUEST: begin
                    read_q  <= 1'b0;
                    state_q <= WAIT_READY;
                end
                WAIT_READY: if (rate_if.events_rate_ready) begin
                    for (int i = 0; i < CHANNEL_NUMBER; i++) snap_q[i] <= rate_if.event_count[i];
                    out_valid_q <= 1'b1;
                    out_data_q  <= {first_idx, rate_if.event_count[first_idx[IW-1:0]]};
                    out_last_q  <= first_idx == last_idx;
                    idx_q       <= first_idx;
                    state_q     <= STREAM;
                end else if (timer_done) begin
                    timeout_q <= 1'b1;
                    clear_q   <= 1'b1;
                    state_q   <= CLEAR;
                end
                STREAM: if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        out_last_q  <= 1'b0;
                        clear_q     <= 1'b1;
                        state_q     <= CLEAR;
                    end else begin
                        out_data_q <= {next_idx, snap_q[next_idx[IW-1:0]]};
                        out_last_q <= next_idx == last_idx;
                        idx_q      <= next_idx;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rate_if.enable = enable_q;
    assign rate_if.read   = read_q;
    assign rate_if.clear  = clear_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_last       = out_last_q;
    assign busy           = busy_q;
    assign timeout_error  = timeout_q;
endmodule
